ball_fsm: RTL

Ball motion controller for Pong: consumes the 2-bit `bounce` event code from the collision/scoring logic and produces the ball position that logic compares against the paddles. It owns ball direction, per-frame stepping, screen-edge saturation and the serve/re-centre sequence after a point. It sits between the frame-tick generator and the collision/scoring logic, and feeds the VGA renderer.

---
 rtl/ball_fsm_if.sv | 22 ++
 rtl/ball_fsm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ball_fsm_if.sv
// Signal bundle between the ball controller, the frame-tick/collision logic and the renderer.
interface ball_fsm_if;
  logic       frame_tick;
  logic [1:0] bounce;
  logic [9:0] ball_pos_x;
  logic [9:0] ball_pos_y;
  logic [7:0] ball_size_x;
  logic [7:0] ball_size_y;
  logic       dir_x;
  logic       dir_y;
  logic       serving;

  modport master (
    output frame_tick, bounce,
    input  ball_pos_x, ball_pos_y, ball_size_x, ball_size_y, dir_x, dir_y, serving
  );

  modport slave (
    input  frame_tick, bounce,
    output ball_pos_x, ball_pos_y, ball_size_x, ball_size_y, dir_x, dir_y, serving
  );
endinterface

// File: rtl/ball_fsm.sv
// Pong ball motion: per-frame stepping with edge saturation, bounce handling and the
// serve / re-centre sequence after a point.
module ball_fsm #(
  parameter int unsigned SCREEN_X    = 640,
  parameter int unsigned SCREEN_Y    = 480,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned SPEED_X     = 2,
  parameter int unsigned SPEED_Y     = 1,
  parameter int unsigned SERVE_DELAY = 60
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  ball_fsm_if.slave    io_ball
);

  localparam logic [10:0] MAX_X    = 11'(SCREEN_X - BALL_SIZE);
  localparam logic [10:0] MAX_Y    = 11'(SCREEN_Y - BALL_SIZE);
  localparam logic [9:0]  CX       = 10'((SCREEN_X - BALL_SIZE) / 2);
  localparam logic [9:0]  CY       = 10'((SCREEN_Y - BALL_SIZE) / 2);
  localparam logic [10:0] HALF_X   = 11'(SCREEN_X / 2);
  localparam logic [10:0] HALF_Y   = 11'(SCREEN_Y / 2);
  localparam logic [10:0] STEP_X   = 11'(SPEED_X);
  localparam logic [10:0] STEP_Y   = 11'(SPEED_Y);
  localparam logic [7:0]  LAST_CNT = 8'((SERVE_DELAY == 0) ? 0 : SERVE_DELAY - 1);

  typedef enum logic {StServe, StMove} state_e;

  state_e     r_state, w_state_d;
  logic [7:0] r_cnt, w_cnt_d;
  logic [9:0] r_pos_x, w_pos_x_d, r_pos_y, w_pos_y_d;
  logic       r_dir_x, w_dir_x_d, r_dir_y, w_dir_y_d;
  logic       r_serve_dir, w_serve_dir_d;
  logic       r_pend_score, w_pend_score_d;
  logic       r_pend_paddle, w_pend_paddle_d;
  logic       r_pend_wall, w_pend_wall_d;

  logic w_ev_score, w_ev_paddle, w_ev_wall;
  logic w_eff_score, w_eff_paddle, w_eff_wall;

  // 11-bit step so neither edge can wrap.
  function automatic logic [9:0] f_step(input logic [9:0] pos, input logic fwd,
                                        input logic [10:0] step, input logic [10:0] lim);
    logic [10:0] ext;
    logic [10:0] sum;
    ext = {1'b0, pos};
    sum = ext + step;
    if (fwd) return (sum > lim) ? lim[9:0] : sum[9:0];
    else     return (ext < step) ? 10'd0 : 10'(ext - step);
  endfunction

  assign w_ev_score   = (io_ball.bounce == 2'b11);
  assign w_ev_paddle  = (io_ball.bounce == 2'b01);
  assign w_ev_wall    = (io_ball.bounce == 2'b10);
  assign w_eff_score  = r_pend_score  | w_ev_score;
  assign w_eff_paddle = r_pend_paddle | w_ev_paddle;
  assign w_eff_wall   = r_pend_wall   | w_ev_wall;

  always_comb begin
    w_state_d       = r_state;
    w_cnt_d         = r_cnt;
    w_pos_x_d       = r_pos_x;
    w_pos_y_d       = r_pos_y;
    w_dir_x_d       = r_dir_x;
    w_dir_y_d       = r_dir_y;
    w_serve_dir_d   = r_serve_dir;
    w_pend_score_d  = 1'b0;
    w_pend_paddle_d = 1'b0;
    w_pend_wall_d   = 1'b0;
    unique case (r_state)
      StServe: begin
        w_pos_x_d = CX;
        w_pos_y_d = CY;
        if (io_ball.frame_tick) begin
          if (r_cnt == LAST_CNT) begin
            w_state_d = StMove;
            w_cnt_d   = 8'd0;
            // serve_dir = 1 means serve to the left.
            w_dir_x_d = ~r_serve_dir;
          end else begin
            w_cnt_d = r_cnt + 8'd1;
          end
        end
      end
      StMove: begin
        w_pend_score_d  = w_eff_score;
        w_pend_paddle_d = w_eff_paddle;
        w_pend_wall_d   = w_eff_wall;
        if (io_ball.frame_tick) begin
          w_pend_score_d  = 1'b0;
          w_pend_paddle_d = 1'b0;
          w_pend_wall_d   = 1'b0;
          if (w_eff_score) begin
            w_state_d     = StServe;
            w_cnt_d       = 8'd0;
            w_pos_x_d     = CX;
            w_pos_y_d     = CY;
            w_serve_dir_d = ~r_serve_dir;
          end else begin
            if (w_eff_paddle) w_dir_x_d = ({1'b0, r_pos_x} < HALF_X);
            if (w_eff_wall)   w_dir_y_d = ({1'b0, r_pos_y} < HALF_Y);
            w_pos_x_d = f_step(r_pos_x, w_dir_x_d, STEP_X, MAX_X);
            w_pos_y_d = f_step(r_pos_y, w_dir_y_d, STEP_Y, MAX_Y);
          end
        end
      end
      default: w_state_d = StServe;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= StServe;
      r_cnt         <= 8'd0;
      r_pos_x       <= CX;
      r_pos_y       <= CY;
      r_dir_x       <= 1'b1;
      r_dir_y       <= 1'b1;
      r_serve_dir   <= 1'b0;
      r_pend_score  <= 1'b0;
      r_pend_paddle <= 1'b0;
      r_pend_wall   <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_pos_x       <= w_pos_x_d;
      r_pos_y       <= w_pos_y_d;
      r_dir_x       <= w_dir_x_d;
      r_dir_y       <= w_dir_y_d;
      r_serve_dir   <= w_serve_dir_d;
      r_pend_score  <= w_pend_score_d;
      r_pend_paddle <= w_pend_paddle_d;
      r_pend_wall   <= w_pend_wall_d;
    end
  end

  assign io_ball.ball_pos_x  = r_pos_x;
  assign io_ball.ball_pos_y  = r_pos_y;
  assign io_ball.ball_size_x = 8'(BALL_SIZE);
  assign io_ball.ball_size_y = 8'(BALL_SIZE);
  assign io_ball.dir_x       = r_dir_x;
  assign io_ball.dir_y       = r_dir_y;
  assign io_ball.serving     = (r_state == StServe);

endmodule
